dcache_axi_bridge: RTL and testbench
====================================

DCACHE_AXI_BRIDGE -- requirements
Module: dcache_axi_bridge

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 8, meaning 32-bit words per cache line and AXI burst beats; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port resetn, input, 1, reset; asynchronous assert, active-low.
REQ-004 SHALL have cache-read ports: miss in 1 (refill request, level); miss_addr in 32; rdata out 32; rvalid out 1 (one pulse per refill beat).
REQ-005 SHALL have cache-write ports: write_back in 1 (level); wb_addr in 32; wb_wdata in 32; wb_wvalid in 1; wb_wlast in 1; wready out 1; bvalid out 1 (one-cycle completion pulse).
REQ-006 SHALL have AXI4 AR ports: arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arvalid 1 (all out); arready 1 in.
REQ-007 SHALL have AXI4 R ports: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 (all in); rready 1 out. AXI-side names carry prefix m_.
REQ-008 SHALL have AXI4 AW/W/B ports mirroring AR/R: awid/awaddr/awlen/awsize/awburst/awvalid out, awready in; wdata 32/wstrb 4/wlast/wvalid out, wready in; bid/bresp/bvalid in, bready out.
REQ-009 SHALL have bus_err out 1, sticky flag set by any non-OKAY rresp or bresp.

Function
REQ-010 SHALL drive constant fields: ids 0, len LINE_WORDS-1, size 3'b010, burst INCR (2'b01), wstrb 4'hF.
REQ-011 SHALL line-align addresses: araddr/awaddr = request address with low log2(LINE_WORDS)+2 bits zeroed, registered at request acceptance.
REQ-012 Read FSM SHALL have states R_IDLE, R_AR, R_DATA, R_DONE.
REQ-013 R_IDLE->R_AR when miss=1 and no line-address conflict (REQ-020); arvalid=1 only in R_AR, held with stable araddr until arready.
REQ-014 R_AR->R_DATA on arvalid&arready; in R_DATA rready=1, rvalid/rdata to cache combinationally equal to AXI rvalid/rdata, no added latency.
REQ-015 R_DATA->R_DONE on rvalid&rlast; R_DONE lasts exactly one cycle, ignores miss, then R_IDLE (prevents re-issue while the cache drops miss).
REQ-016 Write FSM SHALL have states W_IDLE, W_AW, W_DATA, W_RESP, W_DONE, independent of the read FSM.
REQ-017 W_IDLE->W_AW on write_back=1; awvalid held until awready; then W_DATA.
REQ-018 In W_DATA: wvalid=wb_wvalid, wdata=wb_wdata, wlast=wb_wlast, cache wready=AXI wready; on wvalid&wready&wlast -> W_RESP. Beats SHALL NOT be counted or reordered by the bridge.
REQ-019 In W_RESP bready=1; on bvalid -> one-cycle cache bvalid pulse, then W_DONE (one cycle, ignores write_back) -> W_IDLE.
REQ-020 Read issue SHALL stall in R_IDLE while write FSM is not W_IDLE and line address of miss_addr equals latched awaddr; different lines proceed concurrently.
REQ-021 Simultaneous miss and write_back in R_IDLE/W_IDLE: the write SHALL start; the read starts the same cycle only if lines differ.
REQ-022 bus_err SHALL set on rvalid&rready&rresp!=0 or bvalid&bready&bresp!=0; the transaction still completes normally.
REQ-023 No combinational path from any AXI ready input to any AXI valid output.

Reset
REQ-024 resetn=0 SHALL asynchronously force R_IDLE, W_IDLE, latched addresses 0, bus_err 0, and all valid/ready/pulse outputs 0.
REQ-025 Reset mid-burst SHALL abandon the transaction; no beat or bvalid is emitted after release until a new request.

Structure
REQ-026 A shared package SHALL hold read/write state enums and AXI constants (BURST_INCR, SIZE_4B, RESP_OKAY).
REQ-027 Both FSMs SHALL live in this module; no sub-module is needed.

Verification
REQ-028 miss=1, miss_addr=0x1000_0014, arready after 2 cycles, 8 beats D0..D7 -> araddr=0x1000_0000, arlen=7, 8 rvalid pulses D0..D7 in order, one AR only.
REQ-029 write_back, wb_addr=0x2000_0020, 8 beats, wready toggling every cycle, bvalid after 3 cycles -> awaddr=0x2000_0020, 8 W handshakes with wlast on 8th, exactly one cache bvalid pulse.
REQ-030 write_back to 0x3000_0000 pending and miss to 0x3000_0008 -> arvalid stays 0 until W_DONE, then AR issues.
REQ-031 Concurrent write 0x4000_0000 and miss 0x5000_0000 same cycle -> awvalid and arvalid both assert that cycle.
REQ-032 rresp=2'b10 on beat 3 -> bus_err=1 from next cycle, all 8 beats still forwarded, bus_err held until reset.
REQ-033 resetn=0 during R_DATA beat 4 -> all outputs 0 immediately; after release, no rvalid until new miss.

Source files
------------

// File: rtl/dcache_axi_bridge_pkg.sv
// rtl/dcache_axi_bridge_pkg.sv - shared FSM state types and AXI4 constants for the D-cache bridge
package dcache_axi_bridge_pkg;

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_DONE} rd_state_t;
    typedef enum logic [2:0] {W_IDLE, W_AW, W_DATA, W_RESP, W_DONE} wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [3:0] AXI_ID     = 4'd0;
    localparam logic [3:0] WSTRB_ALL  = 4'hF;

endpackage

// File: rtl/dcache_axi_bridge.sv
// rtl/dcache_axi_bridge.sv - D-cache line refill / write-back bridge onto an AXI4 master port
module dcache_axi_bridge
    import dcache_axi_bridge_pkg::*;
#(
    parameter int LINE_WORDS = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        miss,
    input  logic [31:0] miss_addr,
    output logic [31:0] rdata,
    output logic        rvalid,
    input  logic        write_back,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wdata,
    input  logic        wb_wvalid,
    input  logic        wb_wlast,
    output logic        wready,
    output logic        bvalid,
    output logic [3:0]  m_arid,
    output logic [31:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [3:0]  m_rid,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready,
    output logic [3:0]  m_awid,
    output logic [31:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [3:0]  m_bid,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic        bus_err
);

    localparam int          OFFS      = $clog2(LINE_WORDS) + 2;
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFS) - 32'd1);

    rd_state_t   rd_state, rd_next;
    wr_state_t   wr_state, wr_next;
    logic [31:0] ar_addr_q, aw_addr_q;
    logic        bus_err_q;
    logic        wr_accept, rd_accept, rd_conflict;
    logic        unused_ids;

    assign unused_ids = ^{m_rid, m_bid};

    // A write accepted this very cycle blocks a same-line read just like one already in flight.
    assign wr_accept   = (wr_state == W_IDLE) && write_back;
    assign rd_conflict = (wr_state != W_IDLE) ? ((miss_addr & LINE_MASK) == aw_addr_q)
                                              : (write_back && ((miss_addr & LINE_MASK) == (wb_addr & LINE_MASK)));
    assign rd_accept   = (rd_state == R_IDLE) && miss && !rd_conflict;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end

    always_comb begin
        rd_next = rd_state;
        unique case (rd_state)
            R_IDLE:  if (rd_accept) rd_next = R_AR;
            R_AR:    if (m_arready) rd_next = R_DATA;
            R_DATA:  if (m_rvalid && m_rlast) rd_next = R_DONE;
            R_DONE:  rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        wr_next = wr_state;
        unique case (wr_state)
            W_IDLE:  if (write_back) wr_next = W_AW;
            W_AW:    if (m_awready) wr_next = W_DATA;
            W_DATA:  if (wb_wvalid && m_wready && wb_wlast) wr_next = W_RESP;
            W_RESP:  if (m_bvalid) wr_next = W_DONE;
            W_DONE:  wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    // Valids depend only on registered state, so no ready input can reach a valid output.
    always_comb begin
        m_arvalid = (rd_state == R_AR);
        m_rready  = (rd_state == R_DATA);
        rvalid    = (rd_state == R_DATA) && m_rvalid;
        m_awvalid = (wr_state == W_AW);
        m_wvalid  = (wr_state == W_DATA) && wb_wvalid;
        m_wlast   = (wr_state == W_DATA) && wb_wlast;
        wready    = (wr_state == W_DATA) && m_wready;
        m_bready  = (wr_state == W_RESP);
        bvalid    = (wr_state == W_RESP) && m_bvalid;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ar_addr_q <= 32'd0;
            aw_addr_q <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            if (rd_accept) ar_addr_q <= miss_addr & LINE_MASK;
            if (wr_accept) aw_addr_q <= wb_addr & LINE_MASK;
            if ((m_rvalid && m_rready && (m_rresp != RESP_OKAY)) ||
                (m_bvalid && m_bready && (m_bresp != RESP_OKAY)))
                bus_err_q <= 1'b1;
        end
    end

    assign rdata     = m_rdata;
    assign bus_err   = bus_err_q;
    assign m_arid    = AXI_ID;
    assign m_araddr  = ar_addr_q;
    assign m_arlen   = 8'(LINE_WORDS - 1);
    assign m_arsize  = SIZE_4B;
    assign m_arburst = BURST_INCR;
    assign m_awid    = AXI_ID;
    assign m_awaddr  = aw_addr_q;
    assign m_awlen   = 8'(LINE_WORDS - 1);
    assign m_awsize  = SIZE_4B;
    assign m_awburst = BURST_INCR;
    assign m_wdata   = wb_wdata;
    assign m_wstrb   = WSTRB_ALL;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// tb/tb_dcache_axi_bridge.sv - scoreboard bench: random AXI slave, cache-side drivers, reference queues
module tb_dcache_axi_bridge;

    localparam int LW = 8;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } beat_t;

    logic        clk, resetn;
    logic        miss, write_back, wb_wvalid, wb_wlast;
    logic [31:0] miss_addr, wb_addr, wb_wdata;
    logic [31:0] rdata;
    logic        rvalid, wready, bvalid, bus_err;
    logic [3:0]  m_arid, m_rid, m_awid, m_bid;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [7:0]  m_arlen, m_awlen;
    logic [2:0]  m_arsize, m_awsize;
    logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
    logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic [3:0]  m_wstrb;
    logic        m_bvalid, m_bready;

    int          checks = 0;
    int          errors = 0;
    beat_t       exp_rd[$];
    beat_t       exp_w[$];
    logic        exp_b[$];
    logic [31:0] exp_ar[$];
    logic [31:0] exp_aw[$];
    logic        err_model = 1'b0;
    logic        wr_outstanding = 1'b0;
    logic [31:0] wr_line = 32'd0;
    int          rd_err_beat = -1;
    logic        wr_berr = 1'b0;
    logic        wr_toggle = 1'b0;

    dcache_axi_bridge #(.LINE_WORDS(LW)) dut (
        .clk(clk), .resetn(resetn),
        .miss(miss), .miss_addr(miss_addr), .rdata(rdata), .rvalid(rvalid),
        .write_back(write_back), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_wvalid(wb_wvalid),
        .wb_wlast(wb_wlast), .wready(wready), .bvalid(bvalid),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .bus_err(bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return a & ~((32'd1 << ($clog2(LW) + 2)) - 32'd1);
    endfunction

    function automatic logic [31:0] beat_data(input logic [31:0] line, input int b);
        return line ^ (32'h9E37_79B9 * 32'(b + 1));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h time=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_arvalid"}, 32'(m_arvalid), 0);
        chk({nm, "_awvalid"}, 32'(m_awvalid), 0);
        chk({nm, "_wvalid"},  32'(m_wvalid), 0);
        chk({nm, "_rready"},  32'(m_rready), 0);
        chk({nm, "_bready"},  32'(m_bready), 0);
        chk({nm, "_rvalid"},  32'(rvalid), 0);
        chk({nm, "_wready"},  32'(wready), 0);
        chk({nm, "_bvalid"},  32'(bvalid), 0);
        chk({nm, "_bus_err"}, 32'(bus_err), 0);
        chk({nm, "_araddr"},  m_araddr, 0);
        chk({nm, "_awaddr"},  m_awaddr, 0);
    endtask

    task automatic do_read(input logic [31:0] a, input int eb);
        logic [31:0] ln;
        int t;
        ln = line_of(a);
        exp_ar.push_back(ln);
        for (int b = 0; b < LW; b++) exp_rd.push_back('{d: beat_data(ln, b), e: (b == eb)});
        rd_err_beat = eb;
        miss_addr = a;
        miss = 1'b1;
        t = 0;
        while (exp_rd.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rd_done", 32'(exp_rd.size()), 0);
        exp_rd.delete();
        miss = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic berr);
        logic [31:0] ln;
        logic [31:0] wd [LW];
        int b, t;
        ln = line_of(a);
        wr_line = ln;
        wr_outstanding = 1'b1;
        exp_aw.push_back(ln);
        for (int i = 0; i < LW; i++) begin
            wd[i] = $urandom;
            exp_w.push_back('{d: wd[i], e: (i == LW - 1)});
        end
        exp_b.push_back(berr);
        wr_berr = berr;
        wb_addr = a;
        write_back = 1'b1;
        b = 0;
        t = 0;
        wb_wvalid = 1'b1;
        wb_wdata = wd[0];
        wb_wlast = (LW == 1);
        while (b < LW && t < 2000) begin
            @(negedge clk);
            t++;
            if (wready) begin
                b++;
                @(posedge clk); #1;
                if (b < LW) begin
                    wb_wdata = wd[b];
                    wb_wlast = (b == LW - 1);
                end
            end
        end
        wb_wvalid = 1'b0;
        wb_wlast = 1'b0;
        chk("wr_beats", 32'(b), 32'(LW));
        t = 0;
        while (exp_b.size() != 0 && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        chk("wr_done", 32'(exp_b.size()), 0);
        exp_b.delete();
        exp_w.delete();
        wr_outstanding = 1'b0;
        write_back = 1'b0;
    endtask

    // AXI read slave: random arready, random rvalid gaps, data derived from the accepted address
    initial begin : axi_rd_slave
        logic [31:0] line;
        int b, eb;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rresp = 2'b00; m_rlast = 1'b0; m_rid = 4'd0;
        forever begin
            @(negedge clk);
            if (resetn && m_arvalid && m_arready) begin
                line = m_araddr;
                eb = rd_err_beat;
                @(posedge clk); #1;
                m_arready = 1'b0;
                b = 0;
                while (b < LW && resetn) begin
                    m_rvalid = ($urandom_range(0, 3) != 0);
                    m_rdata = beat_data(line, b);
                    m_rresp = (b == eb) ? 2'b10 : 2'b00;
                    m_rlast = (b == LW - 1);
                    @(negedge clk);
                    if (m_rvalid && m_rready) b++;
                    @(posedge clk); #1;
                end
                m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
            end else begin
                @(posedge clk); #1;
                m_arready = m_arvalid && ($urandom_range(0, 2) == 0);
            end
        end
    end

    // AXI write slave: random awready, random or toggling wready, delayed B response
    initial begin : axi_wr_slave
        logic done;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00; m_bid = 4'd0;
        forever begin
            @(negedge clk);
            if (resetn && m_awvalid && m_awready) begin
                @(posedge clk); #1;
                m_awready = 1'b0;
                done = 1'b0;
                while (!done && resetn) begin
                    m_wready = wr_toggle ? !m_wready : ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    if (m_wvalid && m_wready && m_wlast) done = 1'b1;
                    @(posedge clk); #1;
                end
                m_wready = 1'b0;
                repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                m_bvalid = 1'b1;
                m_bresp = wr_berr ? 2'b10 : 2'b00;
                while (resetn) begin
                    @(negedge clk);
                    if (m_bready) break;
                end
                @(posedge clk); #1;
                m_bvalid = 1'b0; m_bresp = 2'b00;
            end else begin
                @(posedge clk); #1;
                m_awready = m_awvalid && ($urandom_range(0, 2) == 0);
            end
        end
    end

    // Monitor: compares every DUT-presented output against the expectation queues
    initial begin : monitor
        beat_t e;
        logic  set_err;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                err_model = 1'b0;
                continue;
            end
            set_err = 1'b0;
            chk("bus_err", 32'(bus_err), 32'(err_model));
            if (exp_rd.size() == 0) chk("rd_unexpected", 32'(rvalid), 0);
            else if (rvalid) begin
                e = exp_rd.pop_front();
                chk("rdata", rdata, e.d);
                if (e.e) set_err = 1'b1;
            end
            if (exp_ar.size() == 0) chk("ar_unexpected", 32'(m_arvalid), 0);
            else if (m_arvalid) begin
                chk("araddr", m_araddr, exp_ar[0]);
                if (m_arready) begin
                    chk("arlen", 32'(m_arlen), 32'(LW - 1));
                    chk("arsize", 32'(m_arsize), 32'd2);
                    chk("arburst", 32'(m_arburst), 32'd1);
                    chk("arid", 32'(m_arid), 0);
                    void'(exp_ar.pop_front());
                end
            end
            chk("ar_stall", 32'(m_arvalid && wr_outstanding && (m_araddr == wr_line)), 0);
            if (exp_aw.size() == 0) chk("aw_unexpected", 32'(m_awvalid), 0);
            else if (m_awvalid) begin
                chk("awaddr", m_awaddr, exp_aw[0]);
                if (m_awready) begin
                    chk("awlen", 32'(m_awlen), 32'(LW - 1));
                    chk("awsize", 32'(m_awsize), 32'd2);
                    chk("awburst", 32'(m_awburst), 32'd1);
                    chk("awid", 32'(m_awid), 0);
                    void'(exp_aw.pop_front());
                end
            end
            if (exp_w.size() == 0) chk("w_unexpected", 32'(m_wvalid), 0);
            else if (m_wvalid && m_wready) begin
                e = exp_w.pop_front();
                chk("wdata", m_wdata, e.d);
                chk("wlast", 32'(m_wlast), 32'(e.e));
                chk("wstrb", 32'(m_wstrb), 32'hF);
            end
            if (exp_b.size() == 0) chk("b_unexpected", 32'(bvalid), 0);
            else if (bvalid) begin
                checks++;
                if (exp_b.pop_front()) set_err = 1'b1;
                wr_outstanding = 1'b0;
            end
            if (set_err) err_model = 1'b1;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int t;
        logic [31:0] wa, ra;
        int off, mode;
        resetn = 1'b0; miss = 1'b0; miss_addr = 32'd0; write_back = 1'b0; wb_addr = 32'd0;
        wb_wdata = 32'd0; wb_wvalid = 1'b0; wb_wlast = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        do_read(32'h1000_0014, -1);
        repeat (2) begin @(posedge clk); #1; end

        wr_toggle = 1'b1;
        do_write(32'h2000_0020, 1'b0);
        wr_toggle = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        fork
            do_write(32'h3000_0000, 1'b0);
            begin @(posedge clk); #1; do_read(32'h3000_0008, -1); end
        join
        repeat (2) begin @(posedge clk); #1; end

        fork
            do_write(32'h4000_0000, 1'b0);
            do_read(32'h5000_0000, -1);
            begin
                t = 0;
                @(negedge clk);
                while (!(m_arvalid || m_awvalid) && t < 50) begin @(negedge clk); t++; end
                chk("conc_arvalid", 32'(m_arvalid), 1);
                chk("conc_awvalid", 32'(m_awvalid), 1);
            end
        join
        repeat (2) begin @(posedge clk); #1; end

        do_read(32'h6000_0044, 3);
        repeat (2) begin @(posedge clk); #1; end
        chk("bus_err_sticky", 32'(bus_err), 1);

        for (int i = 0; i < 12; i++) begin
            wa = 32'h7000_0000 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2);
            ra = 32'h7000_0000 + (32'($urandom_range(0, 3)) << 5) + (32'($urandom_range(0, 7)) << 2);
            off = $urandom_range(0, 3);
            mode = $urandom_range(0, 2);
            fork
                if (mode != 0) do_write(wa, ($urandom_range(0, 3) == 0));
                begin
                    repeat (off) begin @(posedge clk); #1; end
                    if (mode != 1) do_read(ra, -1);
                end
            join
            repeat (2) begin @(posedge clk); #1; end
        end

        fork
            do_read(32'h8000_0010, -1);
            begin
                t = 0;
                while (exp_rd.size() > LW - 4 && t < 2000) begin @(posedge clk); #1; t++; end
                resetn = 1'b0;
                exp_rd.delete();
                exp_ar.delete();
                #1;
                check_reset_outputs("rst_mid");
            end
        join
        repeat (3) begin @(posedge clk); #1; end
        resetn = 1'b1;
        repeat (20) begin @(posedge clk); #1; end
        chk("post_reset_bus_err", 32'(bus_err), 0);

        do_read(32'h9000_0000, -1);
        repeat (2) begin @(posedge clk); #1; end
        do_write(32'h9000_0100, 1'b0);
        repeat (4) begin @(posedge clk); #1; end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
